// File: rtl/nios2_leds_seq_pkg.sv
// Shared definitions for the LED pattern sequencer.
// Holds the sequencer FSM states, the animation modes, the config register
// offsets and the CTRL/STATUS field positions. The top level and the
// pattern-step logic both import this package.
package nios2_leds_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_WAIT  = 2'd3
    } seq_state_t;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_ROTATE = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } seq_mode_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PERIOD = 2'd1;
    localparam logic [1:0] REG_SEED   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_MODE_LSB   = 1;
    localparam int CTRL_MODE_MSB   = 2;
    localparam int CTRL_W          = 3;

    localparam int STATUS_BUSY_BIT    = 0;
    localparam int STATUS_PATTERN_LSB = 4;

    // Bounce direction encoding
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/nios2_leds_pattern_step.sv
// Combinational next-pattern / next-direction logic for the LED sequencer.
// Ports:
//   mode         - animation mode (static, rotate-left, bounce, blink)
//   pattern      - current LED pattern
//   dir          - current bounce direction (DIR_LEFT / DIR_RIGHT)
//   seed         - seed pattern, used by blink for its "on" phase
//   next_pattern - pattern for the next step
//   next_dir     - bounce direction for the next step
module nios2_leds_pattern_step
    import nios2_leds_seq_pkg::*;
#(
    parameter int LED_W = 10
) (
    input  seq_mode_t        mode,
    input  logic [LED_W-1:0] pattern,
    input  logic             dir,
    input  logic [LED_W-1:0] seed,
    output logic [LED_W-1:0] next_pattern,
    output logic             next_dir
);

    // Bounce reverses on the step that would push the end bit off the
    // edge, shifting the other way instead, so the end value is never
    // repeated. Blink toggles between seed and all-off, using the
    // all-off pattern itself as the phase marker.
    always_comb begin
        next_pattern = pattern;
        next_dir     = dir;
        case (mode)
            MODE_STATIC: begin
                next_pattern = pattern;
            end
            MODE_ROTATE: begin
                next_pattern = {pattern[LED_W-2:0], pattern[LED_W-1]};
            end
            MODE_BOUNCE: begin
                if (dir == DIR_LEFT) begin
                    if (pattern[LED_W-1]) begin
                        next_pattern = pattern >> 1;
                        next_dir     = DIR_RIGHT;
                    end else begin
                        next_pattern = pattern << 1;
                    end
                end else begin
                    if (pattern[0]) begin
                        next_pattern = pattern << 1;
                        next_dir     = DIR_LEFT;
                    end else begin
                        next_pattern = pattern >> 1;
                    end
                end
            end
            MODE_BLINK: begin
                next_pattern = (pattern == '0) ? seed : '0;
            end
            default: begin
                next_pattern = pattern;
            end
        endcase
    end

endmodule

// File: rtl/nios2_leds_sequencer.sv
// Hardware LED pattern engine driving the LED PIO through Avalon-MM writes.
// The CPU programs enable/mode, step period and seed pattern through the
// config slave; while enabled the sequencer issues one single-cycle PIO
// write every PERIOD+1 clocks.
// Ports:
//   clk, reset        - system clock, asynchronous active-high reset
//   cfg_*             - Avalon-MM config slave (zero-latency reads)
//   pio_*             - Avalon-MM master into the LED PIO s1 port
module nios2_leds_sequencer
    import nios2_leds_seq_pkg::*;
#(
    parameter int         LED_W         = 10,
    parameter int         CNT_W         = 24,
    parameter logic [1:0] PIO_DATA_ADDR = 2'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  cfg_address,
    input  logic        cfg_chipselect,
    input  logic        cfg_write_n,
    input  logic [31:0] cfg_writedata,
    output logic [31:0] cfg_readdata,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata
);

    logic [CTRL_W-1:0] ctrl_q;
    logic [CNT_W-1:0]  period_q;
    logic [LED_W-1:0]  seed_q;
    seq_state_t        state_q;
    logic [LED_W-1:0]  pattern_q;
    logic              dir_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              seed_pending_q;
    logic              pio_cs_q;

    logic              cfg_wr, ctrl_wr, period_wr, seed_wr;
    logic [CTRL_W-1:0] eff_ctrl;
    logic              eff_enable;
    seq_mode_t         eff_mode;
    logic [CNT_W-1:0]  period_wdata, eff_period, reload_cnt;
    logic [LED_W-1:0]  eff_seed;
    logic [LED_W-1:0]  step_pattern;
    logic              step_dir;
    logic              cfg_wdata_unused;

    assign cfg_wr    = cfg_chipselect && !cfg_write_n;
    assign ctrl_wr   = cfg_wr && (cfg_address == REG_CTRL);
    assign period_wr = cfg_wr && (cfg_address == REG_PERIOD);
    assign seed_wr   = cfg_wr && (cfg_address == REG_SEED);

    // A config write landing in the same cycle as a step or state decision
    // must already be visible to it, so the FSM works from these merged
    // "effective" values rather than the raw registers.
    assign eff_ctrl     = ctrl_wr ? cfg_writedata[CTRL_W-1:0] : ctrl_q;
    assign eff_enable   = eff_ctrl[CTRL_ENABLE_BIT];
    assign eff_mode     = seq_mode_t'(eff_ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB]);
    assign period_wdata = (cfg_writedata[CNT_W-1:0] == '0) ? CNT_W'(1)
                                                           : cfg_writedata[CNT_W-1:0];
    assign eff_period   = period_wr ? period_wdata : period_q;
    assign reload_cnt   = eff_period - CNT_W'(1);
    assign eff_seed     = seed_wr ? cfg_writedata[LED_W-1:0] : seed_q;
    assign cfg_wdata_unused = ^cfg_writedata[31:CNT_W];

    nios2_leds_pattern_step #(
        .LED_W (LED_W)
    ) u_step (
        .mode         (eff_mode),
        .pattern      (pattern_q),
        .dir          (dir_q),
        .seed         (eff_seed),
        .next_pattern (step_pattern),
        .next_dir     (step_dir)
    );

    // Config register file. PERIOD never holds zero so the counter reload
    // of PERIOD-1 cannot underflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q   <= '0;
            period_q <= CNT_W'(1);
            seed_q   <= '0;
        end else begin
            if (ctrl_wr)   ctrl_q   <= cfg_writedata[CTRL_W-1:0];
            if (period_wr) period_q <= period_wdata;
            if (seed_wr)   seed_q   <= cfg_writedata[LED_W-1:0];
        end
    end

    // Sequencer FSM. The PIO strobe is registered and raised on every
    // transition into WRITE, so it is high for exactly that one cycle.
    // A seed written while running is remembered in seed_pending_q and
    // replaces the next computed step, restarting the bounce leftwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            pattern_q      <= '0;
            dir_q          <= DIR_LEFT;
            cnt_q          <= '0;
            seed_pending_q <= 1'b0;
            pio_cs_q       <= 1'b0;
        end else begin
            pio_cs_q <= 1'b0;
            if (seed_wr) seed_pending_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (eff_enable) state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    pattern_q      <= eff_seed;
                    dir_q          <= DIR_LEFT;
                    cnt_q          <= reload_cnt;
                    seed_pending_q <= 1'b0;
                    pio_cs_q       <= 1'b1;
                    state_q        <= ST_WRITE;
                end
                ST_WRITE: begin
                    state_q <= eff_enable ? ST_WAIT : ST_IDLE;
                end
                ST_WAIT: begin
                    if (!eff_enable) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q == '0) begin
                        if (seed_pending_q || seed_wr) begin
                            pattern_q <= eff_seed;
                            dir_q     <= DIR_LEFT;
                        end else begin
                            pattern_q <= step_pattern;
                            dir_q     <= step_dir;
                        end
                        cnt_q          <= reload_cnt;
                        seed_pending_q <= 1'b0;
                        pio_cs_q       <= 1'b1;
                        state_q        <= ST_WRITE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Zero-latency register readback, zero-extended to the bus width.
    always_comb begin
        cfg_readdata = '0;
        case (cfg_address)
            REG_CTRL:   cfg_readdata = {{(32-CTRL_W){1'b0}}, ctrl_q};
            REG_PERIOD: cfg_readdata = {{(32-CNT_W){1'b0}}, period_q};
            REG_SEED:   cfg_readdata = {{(32-LED_W){1'b0}}, seed_q};
            REG_STATUS: cfg_readdata = {{(32-LED_W-STATUS_PATTERN_LSB){1'b0}},
                                        pattern_q, 3'b000, (state_q != ST_IDLE)};
            default:    cfg_readdata = '0;
        endcase
    end

    assign pio_address    = PIO_DATA_ADDR;
    assign pio_chipselect = pio_cs_q;
    assign pio_write_n    = ~pio_cs_q;
    assign pio_writedata  = {{(32-LED_W){1'b0}}, pattern_q};

endmodule

// File: tb/tb_nios2_leds_sequencer.sv
// Self-checking bench for nios2_leds_sequencer. Expected PIO writes (data
// and spacing in clocks) are queued as each scenario is set up; a monitor
// pops and compares them as writes appear on the PIO port.
module tb_nios2_leds_sequencer;
    import nios2_leds_seq_pkg::*;

    typedef struct {
        logic [9:0] data;
        int         gap;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [1:0]  cfg_address;
    logic        cfg_chipselect;
    logic        cfg_write_n;
    logic [31:0] cfg_writedata;
    logic [31:0] cfg_readdata;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   last_write_cycle = 0;
    int   write_count = 0;

    nios2_leds_sequencer #(
        .LED_W         (10),
        .CNT_W         (24),
        .PIO_DATA_ADDR (2'd0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_address    (cfg_address),
        .cfg_chipselect (cfg_chipselect),
        .cfg_write_n    (cfg_write_n),
        .cfg_writedata  (cfg_writedata),
        .cfg_readdata   (cfg_readdata),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cycle = cycle + 1;
        end
    end

    // Scoreboard monitor: every PIO write must match the head of the queue
    // in data and, where a gap is given, in clocks since the previous write.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (pio_chipselect === 1'b1 && pio_write_n === 1'b0) begin
                write_count = write_count + 1;
                checks = checks + 1;
                if (exp_q.size() == 0) begin
                    errors = errors + 1;
                    $display("[TB] FAIL unexpected_write: got 0x%03h, expected no write", pio_writedata);
                end else begin
                    e = exp_q.pop_front();
                    if (pio_writedata !== {22'b0, e.data}) begin
                        errors = errors + 1;
                        $display("[TB] FAIL write_data: got 0x%08h, expected 0x%08h", pio_writedata, {22'b0, e.data});
                    end
                    checks = checks + 1;
                    if (pio_address !== 2'd0) begin
                        errors = errors + 1;
                        $display("[TB] FAIL write_addr: got %0d, expected 0", pio_address);
                    end
                    if (e.gap != 0) begin
                        checks = checks + 1;
                        if (cycle - last_write_cycle != e.gap) begin
                            errors = errors + 1;
                            $display("[TB] FAIL write_gap: got %0d clocks, expected %0d (data 0x%03h)", cycle - last_write_cycle, e.gap, e.data);
                        end
                    end
                end
                last_write_cycle = cycle;
            end
        end
    end

    task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        cfg_address    = addr;
        cfg_writedata  = data;
        cfg_chipselect = 1'b1;
        cfg_write_n    = 1'b0;
        @(negedge clk);
        cfg_chipselect = 1'b0;
        cfg_write_n    = 1'b1;
        cfg_writedata  = '0;
    endtask

    task automatic cfg_read(input logic [1:0] addr, output logic [31:0] data);
        @(negedge clk);
        cfg_address    = addr;
        cfg_chipselect = 1'b1;
        #1;
        data = cfg_readdata;
        cfg_chipselect = 1'b0;
    endtask

    task automatic push_exp(input logic [9:0] data, input int gap);
        exp_t e;
        e.data = data;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    // Bounded wait for all queued writes to appear.
    task automatic drain(input string name, input int bound);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < bound) begin
            @(posedge clk);
            t++;
        end
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("[TB] FAIL %s_timeout: %0d writes still pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int bad;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        cfg_read(REG_STATUS, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("[TB] FAIL reset_status: got 0x%08h, expected 0", rd); end
        cfg_read(REG_CTRL, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("[TB] FAIL reset_ctrl: got 0x%08h, expected 0", rd); end
        cfg_read(REG_PERIOD, rd);
        checks++; if (rd !== 32'd1) begin errors++; $display("[TB] FAIL reset_period: got 0x%08h, expected 1", rd); end
        cfg_read(REG_SEED, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("[TB] FAIL reset_seed: got 0x%08h, expected 0", rd); end
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL reset_idle: got %0d active cycles, expected 0", bad); end
    endtask

    task automatic test_rotate();
        logic [9:0] p;
        p = 10'h001;
        push_exp(p, 0);
        for (int i = 0; i < 10; i++) begin
            p = {p[8:0], p[9]};
            push_exp(p, 4);
        end
        cfg_write(REG_SEED, 32'h001);
        cfg_write(REG_PERIOD, 32'd3);
        cfg_write(REG_CTRL, 32'b011);
        drain("rotate", 200);
        cfg_write(REG_CTRL, 32'b000);
        repeat (10) @(negedge clk);
    endtask

    task automatic test_bounce();
        logic [9:0] v;
        v = 10'h003;
        for (int i = 0; i < 9; i++) push_exp(v << i, (i == 0) ? 0 : 2);
        v = 10'h300;
        for (int i = 1; i < 9; i++) push_exp(v >> i, 2);
        push_exp(10'h006, 2);
        cfg_write(REG_SEED, 32'h003);
        cfg_write(REG_PERIOD, 32'd1);
        cfg_write(REG_CTRL, 32'b101);
        drain("bounce", 200);
        cfg_write(REG_CTRL, 32'b000);
        repeat (10) @(negedge clk);
    endtask

    task automatic test_blink_disable();
        logic [31:0] rd;
        int wc;
        push_exp(10'h2AA, 0);
        push_exp(10'h000, 6);
        push_exp(10'h2AA, 6);
        push_exp(10'h000, 6);
        cfg_write(REG_SEED, 32'h2AA);
        cfg_write(REG_PERIOD, 32'd5);
        cfg_write(REG_CTRL, 32'b111);
        drain("blink", 200);
        wc = write_count;
        cfg_write(REG_CTRL, 32'b110);
        cfg_read(REG_STATUS, rd);
        checks++; if (rd[0] !== 1'b0) begin errors++; $display("[TB] FAIL blink_busy: got %0b, expected 0", rd[0]); end
        repeat (30) @(negedge clk);
        checks++; if (write_count != wc) begin errors++; $display("[TB] FAIL blink_stop: got %0d extra writes, expected 0", write_count - wc); end
        cfg_write(REG_CTRL, 32'b000);
    endtask

    task automatic test_period();
        logic [31:0] rd;
        cfg_write(REG_PERIOD, 32'd0);
        cfg_read(REG_PERIOD, rd);
        checks++; if (rd !== 32'd1) begin errors++; $display("[TB] FAIL period_zero: got %0d, expected 1", rd); end
        cfg_write(REG_SEED, 32'h001);
        push_exp(10'h001, 0);
        push_exp(10'h002, 2);
        push_exp(10'h004, 2);
        push_exp(10'h008, 2);
        cfg_write(REG_CTRL, 32'b011);
        drain("period1", 100);
        cfg_write(REG_CTRL, 32'b000);
        repeat (5) @(negedge clk);
        cfg_write(REG_PERIOD, 32'd7);
        push_exp(10'h001, 0);
        push_exp(10'h002, 8);
        cfg_write(REG_CTRL, 32'b011);
        drain("period7", 100);
        repeat (2) @(posedge clk);
        push_exp(10'h004, 8);
        push_exp(10'h008, 11);
        push_exp(10'h010, 11);
        cfg_write(REG_PERIOD, 32'd10);
        cfg_read(REG_PERIOD, rd);
        checks++; if (rd !== 32'd10) begin errors++; $display("[TB] FAIL period_live: got %0d, expected 10", rd); end
        drain("period10", 100);
        cfg_write(REG_CTRL, 32'b000);
        repeat (10) @(negedge clk);
    endtask

    task automatic test_live_update();
        cfg_write(REG_SEED, 32'h001);
        cfg_write(REG_PERIOD, 32'd3);
        push_exp(10'h001, 0);
        cfg_write(REG_CTRL, 32'b011);
        drain("live_start", 50);
        push_exp(10'h0F0, 4);
        push_exp(10'h1E0, 4);
        cfg_write(REG_SEED, 32'h0F0);
        drain("live_seed", 50);
        push_exp(10'h3C0, 4);
        push_exp(10'h1E0, 4);
        cfg_write(REG_CTRL, 32'b101);
        drain("live_mode", 50);
        cfg_write(REG_CTRL, 32'b000);
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_midwrite();
        logic [31:0] rd;
        int found;
        int wc;
        cfg_write(REG_SEED, 32'h001);
        cfg_write(REG_PERIOD, 32'd3);
        cfg_write(REG_CTRL, 32'b011);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(posedge clk);
            #1;
            if (pio_chipselect === 1'b1) found = 1;
        end
        checks++; if (found == 0) begin errors++; $display("[TB] FAIL midwrite_start: got no write, expected one within 20 clocks"); end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1 || pio_writedata !== 32'd0) begin
            errors++;
            $display("[TB] FAIL midwrite_reset: got cs=%b wn=%b data=0x%08h, expected cs=0 wn=1 data=0", pio_chipselect, pio_write_n, pio_writedata);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wc = write_count;
        cfg_read(REG_STATUS, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("[TB] FAIL midwrite_status: got 0x%08h, expected 0", rd); end
        repeat (30) @(negedge clk);
        checks++; if (write_count != wc) begin errors++; $display("[TB] FAIL midwrite_quiet: got %0d writes, expected 0", write_count - wc); end
        cfg_write(REG_SEED, 32'h005);
        push_exp(10'h005, 0);
        push_exp(10'h00A, 2);
        push_exp(10'h014, 2);
        cfg_write(REG_CTRL, 32'b011);
        drain("midwrite_restart", 50);
        cfg_write(REG_CTRL, 32'b000);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        reset          = 1'b1;
        cfg_address    = 2'd0;
        cfg_chipselect = 1'b0;
        cfg_write_n    = 1'b1;
        cfg_writedata  = 32'd0;
        test_reset();
        test_rotate();
        test_bounce();
        test_blink_disable();
        test_period();
        test_live_update();
        test_reset_midwrite();
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
